// File: rtl/maxpool_relu_pkg.sv
// Shared types and default dimensions for the maxpool_relu slice.
package maxpool_relu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_KERNELS    = 3;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_IN_ROWS    = 26;
  localparam int unsigned DEF_IN_COLS    = 26;

  localparam int unsigned POOL_ROWS = DEF_IN_ROWS / 2;
  localparam int unsigned POOL_COLS = DEF_IN_COLS / 2;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_relu_line_buffer.sv
// Partial-max storage for one pooled row, addressed by column-pair index.
module pool_line_buffer
  import maxpool_relu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = POOL_COLS,
  parameter int unsigned IDX_W      = idx_width(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clear,
  input  logic                         i_wr_en,
  input  logic [IDX_W-1:0]             i_wr_idx,
  input  logic signed [DATA_WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0]             i_rd_idx,
  output logic signed [DATA_WIDTH-1:0] o_rd_data
);

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Entry storage: cleared on reset and at frame start, written on even rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/maxpool_relu.sv
// 2x2 stride-2 signed max-pool over a kernel-major pixel stream.
// Optional feature: define MAXPOOL_RELU_EN to clamp each pixel to max(x,0)
// before pooling; otherwise negative maxima pass through unchanged.
module maxpool_relu
  import maxpool_relu_pkg::*;
#(
  parameter int unsigned KERNELS    = DEF_KERNELS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IN_ROWS    = DEF_IN_ROWS,
  parameter int unsigned IN_COLS    = DEF_IN_COLS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         done
);

  localparam int unsigned P_ROWS = IN_ROWS / 2;
  localparam int unsigned P_COLS = IN_COLS / 2;
  localparam int unsigned CW     = idx_width(IN_COLS);
  localparam int unsigned RW     = idx_width(IN_ROWS);
  localparam int unsigned KW     = idx_width(KERNELS);
  localparam int unsigned PW     = idx_width(P_COLS);

  localparam logic [CW-1:0] COL_LAST      = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IN_ROWS - 1);
  localparam logic [KW-1:0] KERN_LAST     = KW'(KERNELS - 1);
  localparam logic [CW-1:0] COL_PAIR_LAST = CW'(2 * P_COLS - 1);
  localparam logic [RW-1:0] ROW_PAIR_LAST = RW'(2 * P_ROWS - 1);

  state_t                  r_state;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic [KW-1:0]           r_kern;
  logic                    r_in_done;
  logic signed [DATA_WIDTH-1:0] r_hold;
  logic                    r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_out_data;
  logic                    r_out_last;
  logic                    r_done;

  logic signed [DATA_WIDTH-1:0] w_px;
  logic signed [DATA_WIDTH-1:0] w_pair_max;
  logic signed [DATA_WIDTH-1:0] w_lb_rd;
  logic signed [DATA_WIDTH-1:0] w_win_max;
  logic [PW-1:0]           w_pair_idx;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_out_fire;
  logic                    w_start_ok;
  logic                    w_col_keep;
  logic                    w_row_keep;
  logic                    w_pair_done;
  logic                    w_lb_wr;
  logic                    w_win_done;
  logic                    w_win_last;

  // Handshakes, pixel clamp and the pairwise/window max datapath.
  always_comb begin
    w_in_ready = (r_state == ST_RUN) && !r_in_done && !(r_out_valid && !out_ready);
    w_accept   = w_in_ready && in_valid;
    w_out_fire = r_out_valid && out_ready;
    w_start_ok = start && (r_state != ST_RUN);
`ifdef MAXPOOL_RELU_EN
    w_px = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    w_px = in_data;
`endif
    w_pair_max  = (w_px > r_hold) ? w_px : r_hold;
    w_win_max   = (w_pair_max > w_lb_rd) ? w_pair_max : w_lb_rd;
    w_pair_idx  = PW'(r_col >> 1);
    // The trailing row/col of an odd dimension never closes a pair.
    w_col_keep  = ((IN_COLS % 2) == 0) || (r_col != COL_LAST);
    w_row_keep  = ((IN_ROWS % 2) == 0) || (r_row != ROW_LAST);
    w_pair_done = w_accept && r_col[0] && w_col_keep && w_row_keep;
    w_lb_wr     = w_pair_done && !r_row[0];
    w_win_done  = w_pair_done && r_row[0];
    w_win_last  = (r_kern == KERN_LAST) && (r_row == ROW_PAIR_LAST) &&
                  (r_col == COL_PAIR_LAST);
  end

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (P_COLS),
    .IDX_W      (PW)
  ) u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_start_ok),
    .i_wr_en   (w_lb_wr),
    .i_wr_idx  (w_pair_idx),
    .i_wr_data (w_pair_max),
    .i_rd_idx  (w_pair_idx),
    .o_rd_data (w_lb_rd)
  );

  // Frame FSM with scan counters and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_kern      <= '0;
      r_in_done   <= 1'b0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_col       <= '0;
            r_row       <= '0;
            r_kern      <= '0;
            r_in_done   <= 1'b0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (!r_col[0]) r_hold <= w_px;
            if (r_col == COL_LAST) begin
              r_col <= '0;
              if (r_row == ROW_LAST) begin
                r_row <= '0;
                if (r_kern == KERN_LAST) begin
                  r_kern    <= '0;
                  r_in_done <= 1'b1;
                end else begin
                  r_kern <= r_kern + 1'b1;
                end
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
          // A new window may land in the same cycle the old result drains.
          if (w_win_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_win_max;
            r_out_last  <= w_win_last;
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
          if (w_out_fire && r_out_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule

// File: tb/tb_maxpool_relu.sv
`timescale 1ns/1ps
// Scoreboard bench for maxpool_relu: a 3x26x26 instance and a 2x5x5 instance.
module tb_maxpool_relu;

  localparam int K    = 3;
  localparam int DW   = 32;
  localparam int IR   = 26;
  localparam int IC   = 26;
  localparam int PR   = IR / 2;
  localparam int PC   = IC / 2;
  localparam int NOUT = K * PR * PC;
  localparam int K5   = 2;
  localparam int N5   = 5;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic signed [DW-1:0] in_data, out_data;
  logic s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_done;
  logic signed [DW-1:0] s_in_data, s_out_data;

  always #5 clk = ~clk;

  maxpool_relu #(.KERNELS(K), .DATA_WIDTH(DW), .IN_ROWS(IR), .IN_COLS(IC)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done)
  );

  maxpool_relu #(.KERNELS(K5), .DATA_WIDTH(DW), .IN_ROWS(N5), .IN_COLS(N5)) u_dut5 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_last(s_out_last), .done(s_done)
  );

  typedef struct { longint d; bit last; } exp_t;
  exp_t q[$];
  exp_t q5[$];
  int n_total = 0;
  int n_bad   = 0;
  int out_cnt = 0;
  int out_cnt5 = 0;
  int stall_cnt = 0;
  logic signed [DW-1:0] fr [K][IR][IC];

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint relu_m(input longint x);
`ifdef MAXPOOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic longint max2(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  function automatic longint win_exp(input int k, input int i, input int j);
    return max2(max2(relu_m(fr[k][2*i][2*j]),   relu_m(fr[k][2*i][2*j+1])),
                max2(relu_m(fr[k][2*i+1][2*j]), relu_m(fr[k][2*i+1][2*j+1])));
  endfunction

  function automatic longint f5(input int k, input int r, input int c);
    if (r == 4 || c == 4) return 900;
    return k * 50 + r * 5 + c - 12;
  endfunction

  function automatic longint win5(input int k, input int i, input int j);
    return max2(max2(relu_m(f5(k, 2*i, 2*j)),   relu_m(f5(k, 2*i, 2*j+1))),
                max2(relu_m(f5(k, 2*i+1, 2*j)), relu_m(f5(k, 2*i+1, 2*j+1))));
  endfunction

  // Consumer-side backpressure generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor for the 26x26 instance.
  bit done_due = 0;
  bit prev_stall = 0;
  logic signed [DW-1:0] prev_data;
  always @(negedge clk) begin
    exp_t e;
    if (done_due) begin
      check_val("done_after_last", done, 1);
      done_due = 0;
    end
    if (prev_stall) begin
      check_val("stall_valid", out_valid, 1);
      check_val("stall_data", out_data, prev_data);
    end
    if (out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check_val("extra_out", out_valid, 0);
      end else begin
        e = q.pop_front();
        check_val("out_data", out_data, e.d);
        check_val("out_last", out_last, e.last);
      end
      out_cnt++;
      if (out_last) begin
        check_val("done_before_last", done, 0);
        done_due = 1;
      end
    end
  end

  // Monitor for the 5x5 instance.
  always @(negedge clk) begin
    exp_t e;
    if (s_out_valid && s_out_ready) begin
      if (q5.size() == 0) begin
        check_val("s_extra_out", s_out_valid, 0);
      end else begin
        e = q5.pop_front();
        check_val("s_out_data", s_out_data, e.d);
        check_val("s_out_last", s_out_last, e.last);
      end
      out_cnt5++;
    end
  end

  task automatic drive_px(input logic signed [DW-1:0] v, output bit ok);
    in_valid = 1'b1;
    in_data  = v;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // mode 0: ramp r*IC+c, mode 1: random with fixed corner windows.
  task automatic run_frame(input int mode, input int n_stop);
    int idx;
    bit ok;
    exp_t e;
    for (int k = 0; k < K; k++)
      for (int r = 0; r < IR; r++)
        for (int c = 0; c < IC; c++)
          fr[k][r][c] = (mode == 0) ? DW'(r * IC + c)
                                    : DW'(int'($urandom_range(0, 2000)) - 1000);
    if (mode == 1) begin
      fr[0][0][0] = 5;  fr[0][0][1] = -3; fr[0][1][0] = 7;  fr[0][1][1] = 2;
      fr[0][0][2] = -5; fr[0][0][3] = -3; fr[0][1][2] = -7; fr[0][1][3] = -2;
    end
    out_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    for (int k = 0; k < K; k++) begin
      for (int r = 0; r < IR; r++) begin
        for (int c = 0; c < IC; c++) begin
          if (idx == n_stop) return;
          if (mode == 1 && idx == 600) stall_cnt = 10;
          if (r % 2 == 1 && c % 2 == 1 && r < 2 * PR && c < 2 * PC) begin
            e.d    = win_exp(k, r / 2, c / 2);
            e.last = (k == K - 1) && (r == 2 * PR - 1) && (c == 2 * PC - 1);
            q.push_back(e);
          end
          drive_px(fr[k][r][c], ok);
          if (!ok) begin
            check_val("in_accept", in_ready, 1);
            return;
          end
          if (mode == 1 && idx == IC + 1) begin
            @(negedge clk);
            check_val("first_latency_valid", out_valid, 1);
            check_val("first_out_data", out_data, 7);
            @(posedge clk); #1;
          end
          idx++;
        end
      end
    end
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) break;
    end
    check_val("frame_done", done, 1);
    check_val("out_count", out_cnt, NOUT);
    check_val("queue_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check_val({tag, "_in_ready"},  in_ready, 0);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_data"},  out_data, 0);
    check_val({tag, "_out_last"},  out_last, 0);
    check_val({tag, "_done"},      done, 0);
  endtask

  task automatic run_small;
    exp_t e;
    bit stop, acc;
    out_cnt5 = 0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    stop = 0;
    for (int k = 0; k < K5; k++) begin
      for (int r = 0; r < N5; r++) begin
        for (int c = 0; c < N5; c++) begin
          if (!stop) begin
            if (r % 2 == 1 && c % 2 == 1 && r < 4 && c < 4) begin
              e.d    = win5(k, r / 2, c / 2);
              e.last = (k == K5 - 1) && (r == 3) && (c == 3);
              q5.push_back(e);
            end
            s_in_valid = 1'b1;
            s_in_data  = DW'(f5(k, r, c));
            acc = 0;
            for (int t = 0; t < 100; t++) begin
              @(negedge clk);
              if (s_in_ready) begin
                acc = 1;
                break;
              end
              if (s_done) break;
            end
            if (acc) begin
              @(posedge clk); #1;
            end else begin
              stop = 1;
            end
            s_in_valid = 1'b0;
          end
        end
      end
    end
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_done) break;
    end
    check_val("s_done", s_done, 1);
    check_val("s_out_count", out_cnt5, K5 * 4);
    check_val("s_queue_empty", q5.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_val("s_reset_out_valid", s_out_valid, 0);
    check_val("s_reset_in_ready", s_in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("idle");

    run_frame(1, -1);
    run_frame(0, -1);

    run_frame(0, 100);
    rst = 1'b1;
    q.delete();
    check_idle_outputs("abort");
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check_val("abort_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check_val("post_reset_quiet", out_valid, 0);
    end
    run_frame(1, -1);

    run_small();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/maxpool_relu.md
MAXPOOL_RELU -- requirements
Module: maxpool_relu

Interface
REQ-001 Parameter: KERNELS, default 3, number of feature maps per frame.
REQ-002 Parameter: DATA_WIDTH, default 32, signed pixel width.
REQ-003 Parameter: IN_ROWS, default 26, conv output rows per map.
REQ-004 Parameter: IN_COLS, default 26, conv output cols per map.
REQ-005 Port: clk  input  1  single clock, rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous, active-high.
REQ-007 Port: start  input  1  one-cycle pulse, begins a frame.
REQ-008 Port: in_valid  input  1  in_data valid.
REQ-009 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-010 Port: in_data  input  DATA_WIDTH  signed conv pixel, kernel-major, then row, then col order.
REQ-011 Port: out_valid  output  1  out_data valid.
REQ-012 Port: out_ready  input  1  consumer accepts out_data.
REQ-013 Port: out_data  output  DATA_WIDTH  signed pooled pixel.
REQ-014 Port: out_last  output  1  marks final pooled pixel of the frame.
REQ-015 Port: done  output  1  frame complete, held until next start.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when final output handshake completes, DONE->RUN on start.
REQ-017 start in RUN SHALL be ignored; start in IDLE/DONE SHALL clear counters, line buffer and done.
REQ-018 Transfers SHALL occur only on valid&&ready in the same cycle, on both ports.
REQ-019 in_ready SHALL be 1 only in RUN and when !(out_valid && !out_ready).
REQ-020 Pooling SHALL be 2x2, stride 2, signed max; output map size floor(IN_ROWS/2) x floor(IN_COLS/2) = 13x13 by default.
REQ-021 Last row/col of an odd dimension SHALL be accepted and discarded.
REQ-022 Even input rows SHALL store max(pair) per column pair into a floor(IN_COLS/2)-entry line buffer; odd rows SHALL combine pair max with the stored entry.
REQ-023 out_valid SHALL assert the cycle after accepting the bottom-right pixel of a window (latency 1) and hold with stable out_data until accepted.
REQ-024 Simultaneous out handshake and new window completion SHALL load the new result with no bubble.
REQ-025 Column/row/kernel counters SHALL wrap at IN_COLS, IN_ROWS, KERNELS respectively; kernel wrap ends input acceptance.
REQ-026 out_last SHALL be 1 exactly with the KERNELS*13*13-th output.
REQ-027 done SHALL rise the cycle after the out_last handshake.

Reset
REQ-028 rst SHALL asynchronously force IDLE, all counters 0, line buffer 0, in_ready=0, out_valid=0, out_data=0, out_last=0, done=0.
REQ-029 rst mid-frame SHALL abort the frame; no partial output is emitted afterwards.

Configuration
REQ-030 With MAXPOOL_RELU_EN defined, each pixel SHALL be clamped to max(x,0) before pooling; without it, plain signed max-pool with negative results passed through.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, default dimension constants and pooled-size localparams (POOL_ROWS, POOL_COLS).
REQ-032 One sub-module, pool_line_buffer (partial-max storage, read/write by column-pair index), is natural; the rest stays in maxpool_relu.

Verification
REQ-033 Window [5,-3;7,2] kernel 0 top-left, out_ready=1 -> first out_data=7, one cycle after 4th pixel.
REQ-034 All-negative window [-5,-3;-7,-2] -> out_data=0 with MAXPOOL_RELU_EN, -2 without.
REQ-035 Full 3x26x26 ramp frame (pixel = r*26+c) -> 507 outputs, pixel (i,j) = (2i+1)*26+2j+1, out_last on 507th, done next cycle.
REQ-036 out_ready held 0 for 10 cycles mid-frame -> out_data stable, in_ready=0, no pixel lost or duplicated.
REQ-037 IN_ROWS=IN_COLS=5 build -> 2x2 outputs per map, row 4/col 4 discarded.
REQ-038 rst pulse after 100 inputs, then start -> all outputs 0 until new frame, new frame fully correct.
